// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;

  // Arbiter FSM: idle, or one memory access in flight for fetch or data.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  // Which requester won the current grant.
  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } src_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch port, data port and memory port signals around the arbiter.
//
// Handshake: a requester raises *_req with its address (and write data) and
// holds all of it until the matching *_valid pulses for one cycle; dropping
// the request in that same cycle is allowed. The memory side sees mem_req
// with stable mem_addr/mem_we/mem_wdata until it answers with a single-cycle
// mem_ready, and mem_rdata is only meaningful while mem_ready is high.
interface mem_port_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic             if_flush;
  logic [WIDTH-1:0] if_rdata;
  logic             if_valid;

  logic             d_req;
  logic             d_we;
  logic [WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic [WIDTH-1:0] d_rdata;
  logic             d_valid;

  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;

  logic             stall_F;
  logic             stall_MEM;

  // Arbiter view.
  modport slave (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_valid,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_valid,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output stall_F, stall_MEM
  );

  // Pipeline and memory view.
  modport master (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_valid,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  stall_F, stall_MEM
  );
endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Counts consecutive data grants made while a fetch was waiting; sat tells
// the arbiter that the fetch must win the next contested grant.
module mem_arb_starve_cnt #(
  parameter int LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q;

  // Saturating counter; a fetch grant restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != LIM)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign sat = (cnt_q == LIM);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data stages. Data
// normally wins; a fetch that has lost STARVE_LIMIT times in a row wins next.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus,
  output state_t               state_dbg
);
  state_t           state_q, state_d;
  src_t             grant_src;
  logic             grant;
  logic             done;
  logic             starve_sat;
  logic             drop_q;
  logic [WIDTH-1:0] addr_q, wdata_q;
  logic             we_q;
  logic [WIDTH-1:0] if_rdata_q, d_rdata_q;
  logic             if_valid_q, d_valid_q;

  // Grant decision and next state; no grant while a completion is pulsing,
  // so there is always a full idle cycle between accesses.
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    grant_src = SRC_D;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!(if_valid_q || d_valid_q)) begin
          if (bus.d_req && !(bus.if_req && starve_sat)) begin
            grant     = 1'b1;
            grant_src = SRC_D;
            state_d   = BUSY_D;
          end else if (bus.if_req) begin
            grant     = 1'b1;
            grant_src = SRC_IF;
            state_d   = BUSY_IF;
          end
        end
      end
      BUSY_IF, BUSY_D: begin
        if (bus.mem_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the winner's request so the memory port stays stable while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (grant) begin
      if (grant_src == SRC_D) begin
        addr_q  <= bus.d_addr;
        we_q    <= bus.d_we;
        wdata_q <= bus.d_wdata;
      end else begin
        addr_q  <= bus.if_addr;
        we_q    <= 1'b0;
        wdata_q <= '0;
      end
    end
  end

  // A flushed fetch still finishes at the memory, but its result is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= 1'b0;
    end else if (state_d == IDLE) begin
      drop_q <= 1'b0;
    end else if ((state_q == BUSY_IF) && bus.if_flush) begin
      drop_q <= 1'b1;
    end
  end

  // Register read data and raise the one-cycle completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if (done && (state_q == BUSY_IF) && !(drop_q || bus.if_flush)) begin
        if_rdata_q <= bus.mem_rdata;
        if_valid_q <= 1'b1;
      end
      if (done && (state_q == BUSY_D)) begin
        d_valid_q <= 1'b1;
        if (!we_q) begin
          d_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  mem_arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk (clk),
    .rst (rst),
    .inc (grant && (grant_src == SRC_D) && bus.if_req),
    .clr (grant && (grant_src == SRC_IF)),
    .sat (starve_sat)
  );

  assign bus.mem_req   = (state_q != IDLE);
  assign bus.mem_we    = (state_q == BUSY_D) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.stall_F   = bus.if_req & ~if_valid_q;
  assign bus.stall_MEM = bus.d_req & ~d_valid_q;
  assign state_dbg     = state_q;
endmodule
